jtsdram_bank_chk: RTL and testbench

- Per-bank read-and-compare stage; four instances sit directly downstream of the test sequencer, one per SDRAM bank.
- Each instance takes the sequencer's read-start pulse, its 5-bit bank key and the reference data word.
- It issues a sweep of single-word reads to the SDRAM controller port for its bank and compares every returned word with the expected value.
- It returns a done level to the sequencer and keeps sticky error status for the host/OSD.

---
 rtl/jtsdram_pkg.sv | 24 ++
 rtl/jtsdram_errcnt.sv | 42 ++++
 rtl/jtsdram_bank_chk.sv | 130 +++++++++++++
 tb/tb_jtsdram_bank_chk.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM test path: checker FSM encoding, bus widths and the
// expected-data rule used by both the writer (jtsdram_prog) and the per-bank checker.
package jtsdram_pkg;

  localparam int unsigned KEY_W  = 5;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } chk_state_e;

  // Word stored at sweep position cnt: low DATA_W bits of {key, cnt} XOR the reference word.
  function automatic logic [DATA_W-1:0] exp_data(input logic [KEY_W-1:0]  key,
                                                 input logic [31:0]       cnt,
                                                 input int unsigned       cw,
                                                 input logic [DATA_W-1:0] dref);
    logic [31:0] tag;
    tag = ({{(32 - KEY_W){1'b0}}, key} << cw) | cnt;
    return tag[DATA_W-1:0] ^ dref;
  endfunction

endpackage

// File: rtl/jtsdram_errcnt.sv
// Compare-and-account block: sticky mismatch flag, saturating mismatch count and
// capture of the address of the first mismatch seen since reset.
module jtsdram_errcnt #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16,
  parameter int unsigned NW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          chk,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] ref_word,
  input  logic [AW-1:0] addr,
  output logic          mis_any,
  output logic [NW-1:0] cnt,
  output logic [AW-1:0] fail_addr
);

  logic miss;

  always_comb begin
    miss = chk && (din != ref_word);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_any   <= 1'b0;
      cnt       <= '0;
      fail_addr <= '0;
    end else if (miss) begin
      mis_any <= 1'b1;
      if (cnt != {NW{1'b1}}) begin
        cnt <= cnt + 1'b1;
      end
      // Only the first mismatch since reset is recorded.
      if (!mis_any) begin
        fail_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/jtsdram_bank_chk.sv
// Per-bank read-and-compare stage: sweeps 2^CW single-word reads over the bank region
// selected by the latched key and checks each returned word against the expected pattern.
module jtsdram_bank_chk
  import jtsdram_pkg::*;
#(
  parameter int unsigned AW   = 22,
  parameter int unsigned CW   = 8,
  parameter int unsigned TOUT = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] data_ref,
  output logic              done,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  input  logic              ba_ack,
  input  logic              ba_dst,
  input  logic [DATA_W-1:0] ba_din,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [AW-1:0]     fail_addr,
  output logic              timeout
);

  localparam int unsigned TW = $clog2(TOUT + 1);

  chk_state_e        state_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] ref_q;
  logic [CW-1:0]     cnt_q;
  logic [TW-1:0]     timer_q;

  logic              take_data;
  logic [DATA_W-1:0] exp_word;
  logic              mis_any;

  always_comb begin
    ba_addr  = (AW'(key_q) << (AW - KEY_W)) | AW'(cnt_q);
    exp_word = exp_data(key_q, 32'(cnt_q), CW, ref_q);
    // A strobe arriving together with the ack belongs to the read being acknowledged.
    take_data = ba_dst && ((state_q == StWait) || ((state_q == StReq) && ba_ack));
    err       = mis_any | timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      done    <= 1'b1;
      ba_rd   <= 1'b0;
      key_q   <= '0;
      ref_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      timeout <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            key_q   <= key;
            ref_q   <= data_ref;
            cnt_q   <= '0;
            done    <= 1'b0;
            ba_rd   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (ba_ack) begin
            timer_q <= '0;
            if (ba_dst) begin
              if (&cnt_q) begin
                ba_rd   <= 1'b0;
                done    <= 1'b1;
                state_q <= StIdle;
              end else begin
                ba_rd   <= 1'b1;
                cnt_q   <= cnt_q + 1'b1;
                state_q <= StReq;
              end
            end else begin
              ba_rd   <= 1'b0;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (ba_dst) begin
            if (&cnt_q) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              ba_rd   <= 1'b1;
              cnt_q   <= cnt_q + 1'b1;
              state_q <= StReq;
            end
          end else if (timer_q == TW'(TOUT - 1)) begin
            // Abort the sweep; the missing strobe is never waited for again.
            timeout <= 1'b1;
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  jtsdram_errcnt #(
    .AW(AW),
    .DW(DATA_W),
    .NW(8)
  ) u_errcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .chk       (take_data),
    .din       (ba_din),
    .ref_word  (exp_word),
    .addr      (ba_addr),
    .mis_any   (mis_any),
    .cnt       (err_cnt),
    .fail_addr (fail_addr)
  );

endmodule

// File: tb/tb_jtsdram_bank_chk.sv
// Bench for jtsdram_bank_chk: SDRAM controller model plus sweep-level reference model,
// driven from a vector table, hand-written corner sequences and random sweeps.
module tb_jtsdram_bank_chk;

  localparam int unsigned AW    = 22;
  localparam int unsigned CW    = 8;
  localparam int unsigned TOUT  = 63;
  localparam int          NREAD = 256;
  localparam int          LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    key = '0;
  logic [15:0]   data_ref = '0;
  logic          done;
  logic [AW-1:0] ba_addr;
  logic          ba_rd;
  logic          ba_ack = 1'b0;
  logic          ba_dst = 1'b0;
  logic [15:0]   ba_din = '0;
  logic          err;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr;
  logic          timeout;

  always #5 clk = ~clk;

  jtsdram_bank_chk #(
    .AW  (AW),
    .CW  (CW),
    .TOUT(TOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (key),
    .data_ref (data_ref),
    .done     (done),
    .ba_addr  (ba_addr),
    .ba_rd    (ba_rd),
    .ba_ack   (ba_ack),
    .ba_dst   (ba_dst),
    .ba_din   (ba_din),
    .err      (err),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .timeout  (timeout)
  );

  // Controller model configuration
  int          c_lat = 3;
  int          c_ack_dly = 0;
  int          c_withhold = -1;
  bit          c_same = 0;
  bit          c_stray = 0;
  bit          bad[NREAD];
  logic [4:0]  c_key = '0;
  logic [15:0] c_ref = '0;

  // Observations
  int            hs = 0;
  int            addr_errs = 0;
  int            done_rises = 0;
  longint        cycle = 0;
  longint        ack_cyc = 0;
  longint        to_cyc = 0;
  longint        rise_cyc = 0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;

  // Reference model status
  int            m_cnt = 0;
  bit            m_has = 0;
  bit            m_to = 0;
  logic [AW-1:0] m_fail = '0;

  int n_chk = 0;
  int n_pass = 0;

  function automatic logic [15:0] spec_exp(input logic [4:0] k, input int i,
                                           input logic [15:0] r);
    int v;
    v = (int'(k) * 256 + i) % 65536;
    return 16'(v) ^ r;
  endfunction

  function automatic logic [AW-1:0] spec_addr(input logic [4:0] k, input int i);
    return AW'(int'(k) * 131072 + i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      $display("FAIL %s: got %0h, want %0h", name, act, exp_v);
    end else begin
      n_pass++;
    end
  endtask

  // SDRAM controller model and output monitor, all activity on the falling edge.
  initial begin : ctl
    int          rd_seen;
    int          pend_left;
    bit          pend;
    bit          prev_done;
    bit          prev_to;
    logic [15:0] pend_data;
    logic [15:0] d;
    int          a;
    int          k;
    int          i;
    rd_seen   = 0;
    pend      = 0;
    pend_left = 0;
    pend_data = '0;
    prev_done = 1;
    prev_to   = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (done && !prev_done) begin
        done_rises++;
        rise_cyc = cycle;
      end
      if (timeout && !prev_to) to_cyc = cycle;
      prev_done = done;
      prev_to   = timeout;
      ba_ack = 1'b0;
      ba_dst = 1'b0;
      ba_din = 16'($urandom);
      if (pend) begin
        pend_left--;
        if (pend_left <= 0) begin
          ba_dst = 1'b1;
          ba_din = pend_data;
          pend   = 0;
        end
      end else if (ba_rd) begin
        if (rd_seen >= c_ack_dly) begin
          rd_seen = 0;
          ba_ack  = 1'b1;
          if (hs == 0) first_addr = ba_addr;
          last_addr = ba_addr;
          if (ba_addr !== spec_addr(c_key, hs)) addr_errs++;
          a = int'(ba_addr);
          k = a / 131072;
          i = a % 256;
          d = bad[i] ? 16'h1234 : spec_exp(5'(k), i, c_ref);
          if (hs == c_withhold) begin
            ack_cyc = cycle;
          end else if (c_same) begin
            ba_dst = 1'b1;
            ba_din = d;
          end else begin
            pend      = 1;
            pend_left = c_lat;
            pend_data = d;
          end
          hs++;
        end else begin
          if (c_stray && rd_seen == 0) begin
            ba_dst = 1'b1;
            ba_din = 16'hDEAD;
          end
          rd_seen++;
        end
      end else begin
        rd_seen = 0;
      end
    end
  end

  task automatic run_sweep(input logic [4:0] k, input logic [15:0] r, input bit midstart);
    int n_hs;
    int n_data;
    int waited;
    bit to_before;
    c_key      = k;
    c_ref      = r;
    hs         = 0;
    addr_errs  = 0;
    done_rises = 0;
    to_before  = m_to;
    @(negedge clk);
    start    = 1'b1;
    key      = k;
    data_ref = r;
    @(negedge clk);
    start    = 1'b0;
    key      = ~k;
    data_ref = ~r;
    chk("done_low_after_start", done, 0);
    waited = 0;
    while (waited < LIMIT) begin
      @(negedge clk);
      waited++;
      if (done) break;
      start = midstart && (waited == 40);
    end
    start = 1'b0;
    chk("sweep_completes", done, 1);
    repeat (4) @(negedge clk);

    n_hs   = (c_withhold >= 0) ? c_withhold + 1 : NREAD;
    n_data = (c_withhold >= 0) ? c_withhold : NREAD;
    for (int i = 0; i < n_data; i++) begin
      if (bad[i] && spec_exp(k, i, r) != 16'h1234) begin
        if (m_cnt < 255) m_cnt++;
        if (!m_has) begin
          m_has  = 1;
          m_fail = spec_addr(k, i);
        end
      end
    end
    if (c_withhold >= 0) m_to = 1;

    chk("handshakes", hs, n_hs);
    chk("first_addr", first_addr, spec_addr(k, 0));
    chk("last_addr", last_addr, spec_addr(k, n_hs - 1));
    chk("addr_sequence_errors", addr_errs, 0);
    chk("done_rises_once", done_rises, 1);
    chk("ba_rd_idle", ba_rd, 0);
    chk("err", err, m_has | m_to);
    chk("err_cnt", err_cnt, m_cnt);
    chk("fail_addr", fail_addr, m_fail);
    chk("timeout", timeout, m_to);
    if (c_withhold >= 0 && !to_before) begin
      chk("timeout_latency", to_cyc - ack_cyc, TOUT + 1);
      chk("done_with_timeout", rise_cyc, to_cyc);
    end
  endtask

  typedef struct {
    logic [4:0]    key;
    logic [15:0]   dref;
    int            lat;
    int            ack_dly;
    int            bad0;
    int            bad1;
    bit            bad_all;
    int            withhold;
    bit            same;
    bit            stray;
    bit            midstart;
    int            exp_hs;
    logic [AW-1:0] exp_last;
    logic [7:0]    exp_err_cnt;
    logic [AW-1:0] exp_fail;
    bit            exp_to;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5'h0A, 16'hAAAA, 3, 0, -1, -1, 0, -1, 0, 0, 0, 256, 22'h1400FF, 8'd0, 22'h0, 0};
    tbl[1] = '{5'h0A, 16'hAAAA, 3, 0, 16, -1, 0, -1, 0, 0, 0, 256, 22'h1400FF, 8'd1,
               22'h140010, 0};
    tbl[2] = '{5'h0A, 16'hAAAA, 3, 1, 32, 48, 0, -1, 0, 0, 0, 256, 22'h1400FF, 8'd3,
               22'h140010, 0};
    tbl[3] = '{5'h0A, 16'hAAAA, 3, 0, -1, -1, 0, 5, 0, 0, 0, 6, 22'h140005, 8'd3,
               22'h140010, 1};
    tbl[4] = '{5'h15, 16'h5A5A, 2, 0, -1, -1, 0, -1, 1, 0, 0, 256, 22'h2A00FF, 8'd3,
               22'h140010, 1};
    tbl[5] = '{5'h03, 16'h0000, 2, 2, -1, -1, 0, -1, 0, 1, 1, 256, 22'h0600FF, 8'd3,
               22'h140010, 1};
    tbl[6] = '{5'h1F, 16'h0000, 1, 0, -1, -1, 1, -1, 0, 0, 0, 256, 22'h3E00FF, 8'd255,
               22'h140010, 1};
    tbl[7] = '{5'h1F, 16'hFFFF, 1, 0, -1, -1, 1, -1, 0, 0, 0, 256, 22'h3E00FF, 8'd255,
               22'h140010, 1};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1);
    chk("rst_ba_rd", ba_rd, 0);
    chk("rst_ba_addr", ba_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      c_lat      = tbl[v].lat;
      c_ack_dly  = tbl[v].ack_dly;
      c_withhold = tbl[v].withhold;
      c_same     = tbl[v].same;
      c_stray    = tbl[v].stray;
      for (int i = 0; i < NREAD; i++) bad[i] = tbl[v].bad_all;
      if (tbl[v].bad0 >= 0) bad[tbl[v].bad0] = 1;
      if (tbl[v].bad1 >= 0) bad[tbl[v].bad1] = 1;
      run_sweep(tbl[v].key, tbl[v].dref, tbl[v].midstart);
      chk("tbl_handshakes", hs, tbl[v].exp_hs);
      chk("tbl_last_addr", last_addr, tbl[v].exp_last);
      chk("tbl_err_cnt", err_cnt, tbl[v].exp_err_cnt);
      chk("tbl_fail_addr", fail_addr, tbl[v].exp_fail);
      chk("tbl_timeout", timeout, tbl[v].exp_to);
    end

    // Reset while a request is pending: outputs clear without any clock edge.
    c_ack_dly  = 1000;
    c_withhold = -1;
    c_same     = 0;
    c_stray    = 0;
    @(negedge clk);
    start    = 1'b1;
    key      = 5'h0A;
    data_ref = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_before_reset", ba_rd, 1);
    chk("done_before_reset", done, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ba_rd", ba_rd, 0);
    chk("async_rst_done", done, 1);
    chk("async_rst_ba_addr", ba_addr, 0);
    chk("async_rst_err", err, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    chk("async_rst_fail_addr", fail_addr, 0);
    chk("async_rst_timeout", timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt  = 0;
    m_has  = 0;
    m_to   = 0;
    m_fail = '0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 4; s++) begin
      c_lat      = int'($urandom_range(4, 1));
      c_ack_dly  = int'($urandom_range(2, 0));
      c_same     = ($urandom_range(3, 0) == 0);
      c_stray    = (c_ack_dly > 0) && ($urandom_range(3, 0) == 0);
      c_withhold = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : -1;
      for (int i = 0; i < NREAD; i++) bad[i] = ($urandom_range(31, 0) == 0);
      run_sweep(5'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
